div: RTL
========

# div

Sequential 32-bit signed integer divider: the inverse operation to the shift-and-add multiplier in the multdiv unit. It sits beside the multiplier under the multdiv wrapper and shares its start/ready handshake style. It produces quotient, remainder and an exception flag after a fixed latency, using one radix-2 restoring iteration per clock.

## Interface
- WIDTH, 32: operand/result width; only 32 is supported.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- ctrl_DIV  in  1  start strobe; operands sampled on any rising edge where high.
- data_operandA  in  32  dividend, two's complement.
- data_operandB  in  32  divisor, two's complement.
- data_result  out  32  quotient, truncated toward zero; 0 on exception.
- data_remainder  out  32  remainder, sign of dividend; 0 on exception.
- data_exception  out  1  divide-by-zero or overflow (-2^31 / -1).
- data_resultRDY  out  1  one-cycle pulse; outputs valid from this cycle until next start.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ctrl_DIV=1 → BUSY.
  - BUSY: 32 edges, counter 0..31. Counter==31 → DONE.
  - DONE: one edge → IDLE.
- Start edge E0, from any state:
  - Latch |A| into the quotient/shift register and |B| into the divisor register.
  - Clear the 33-bit partial remainder.
  - Latch sign_q = A[31]^B[31] and sign_r = A[31].
  - Latch exc = (B==0) | (A==32'h8000_0000 & B==32'hFFFF_FFFF).
  - Clear counter.
  - Deassert data_resultRDY.
- Iteration (BUSY, each edge):
  - Shift {rem, q} left 1.
  - Trial = rem − divisor, 33-bit.
  - If trial ≥ 0: rem = trial, q[0] = 1. Otherwise rem is unchanged and q[0] = 0.
- DONE edge:
  - data_result = exc ? 0 : (sign_q ? −q : q).
  - data_remainder = exc ? 0 : (sign_r ? −rem[31:0] : rem[31:0]).
  - data_exception = exc.
  - data_resultRDY = 1.
- |−2^31| is held as unsigned 32-bit 0x8000_0000. Arithmetic is on unsigned magnitudes with a 33-bit remainder, so the result is correct for every non-exception case, including −2^31 / 1 and −2^31 / 2.
- Exceptions are not short-circuited. Exception cases take the same latency as normal divides.
- Output registers are loaded only on the DONE edge. They hold their values through IDLE and through the next operation's BUSY phase.
- ctrl_DIV during BUSY or DONE aborts the current operation and restarts with the new operands. The aborted operation never pulses data_resultRDY.

## Timing
- Latency: start on edge E0. The 32 iterations run on E1..E32, DONE is entered after E32, and outputs plus data_resultRDY are registered at E33. data_resultRDY is high E33→E34.
- Back-to-back: ctrl_DIV at E34 is legal. Earliest throughput is one result per 34 cycles. ctrl_DIV at E33 (DONE) counts as a restart, and the previous result is lost.
- Reset (reset_n low, asynchronous, any time):
  - State = IDLE, counter = 0.
  - data_result = 0, data_remainder = 0, data_exception = 0, data_resultRDY = 0.
  - Internal operand registers = 0.
  - Reset dominates a simultaneous ctrl_DIV.
- After reset release, the first edge with ctrl_DIV=1 is E0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package div_pkg:
  - WIDTH = 32.
  - ITER = 32, with counter width 5.
  - Typedef div_state_t {IDLE, BUSY, DONE}.
  - INT_MIN constant = 32'h8000_0000.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem[32:0], q[31:0], divisor[31:0].
  - Outputs: next rem, next q.
- Top: FSM, counter, operand/sign/exception latches, sign-correction negators and output registers.

## Test plan
- 100 / 7, start at E0 → at E33 data_result=14, data_remainder=2, data_exception=0. data_resultRDY high exactly one cycle, and not at E32 or E34.
- Signed cases:
  - −100 / 7 → −14 rem −2.
  - 100 / −7 → −14 rem 2.
  - −100 / −7 → 14 rem −2.
  - −2^31 / 1 → 0x8000_0000 rem 0.
- Divide-by-zero:
  - 5 / 0 → at E33 data_exception=1, result=0, remainder=0, RDY pulse.
  - A following 6 / 3 → exception cleared, result=2.
- Overflow: 0x8000_0000 / 0xFFFF_FFFF → exception=1, result=0 at E33.
- Restart: start 1000/3, then ctrl_DIV with 9/4 at E10 → no RDY pulse for the first operation. RDY at E10+33 with result=2, remainder=1.
- Reset mid-operation: reset_n low at E15 → all outputs 0 immediately. Release, start 81/9 → result=9, remainder=0, after 33 edges.

Source files
------------

// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared constants, the FSM state type and small arithmetic helpers for the
// sequential signed divider (div) and its single-step datapath (div_step).
//
// Contents:
//   WIDTH    operand/result width (only 32 is supported)
//   ITER     number of restoring iterations per divide
//   CNT_W    width of the iteration counter
//   INT_MIN  most negative 32-bit two's-complement value
//   NEG_ONE  all-ones divisor, used for overflow detection
//   div_state_t   IDLE / BUSY / DONE
//   magnitude()   absolute value as an unsigned 32-bit magnitude
//   negate_if()   conditional two's-complement negation
// ----------------------------------------------------------------------------
package div_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 5;

   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
   localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // |v| as an unsigned magnitude. INT_MIN maps onto itself, which read as
   // unsigned is exactly 2^31, so no extra bit is needed.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic              neg,
                                                  input logic [WIDTH-1:0]  v);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step on unsigned magnitudes.
// The {rem, q} pair is shifted left by one, the divisor is trial-subtracted
// from the widened remainder, and the quotient bit shifted in records whether
// the subtraction was kept.
//
// Ports:
//   rem_in    [32:0]  partial remainder before this step
//   q_in      [31:0]  dividend / quotient shift register before this step
//   divisor   [31:0]  divisor magnitude
//   rem_out   [32:0]  partial remainder after this step
//   q_out     [31:0]  quotient shift register after this step
// ----------------------------------------------------------------------------
module div_step
   import div_pkg::*;
(
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] q_out
);

   // One bit wider than the remainder so the sign of the trial difference is
   // unambiguous even if the shifted remainder grows (divide-by-zero runs
   // keep accumulating; that result is discarded later but must stay defined).
   logic [WIDTH+1:0] rem_shift;
   logic [WIDTH+1:0] trial;
   logic             trial_ok;

   always_comb begin
      rem_shift = {rem_in, q_in[WIDTH-1]};
      trial     = rem_shift - {2'b00, divisor};
      trial_ok  = ~trial[WIDTH+1];

      rem_out   = trial_ok ? trial[WIDTH:0] : rem_shift[WIDTH:0];
      q_out     = {q_in[WIDTH-2:0], trial_ok};
   end

endmodule

// File: rtl/div.sv
// ----------------------------------------------------------------------------
// div
// Sequential 32-bit signed integer divider. A start strobe samples both
// operands, 32 restoring iterations (one per clock) run on the magnitudes,
// and the sign-corrected quotient and remainder are registered together with
// an exception flag and a one-cycle ready pulse, 33 edges after the start.
//
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   ctrl_DIV        start strobe; operands sampled on every edge where high,
//                   aborting any operation in flight
//   data_operandA   dividend, two's complement
//   data_operandB   divisor, two's complement
//   data_result     quotient, truncated toward zero; 0 on exception
//   data_remainder  remainder with the sign of the dividend; 0 on exception
//   data_exception  divide-by-zero or INT_MIN / -1 overflow
//   data_resultRDY  one-cycle pulse when a new result is registered
// ----------------------------------------------------------------------------
module div
   import div_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY
);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   div_state_t        state_reg;
   div_state_t        state_next;

   logic [CNT_W-1:0]  cnt_reg;
   logic [WIDTH:0]    rem_reg;
   logic [WIDTH-1:0]  q_reg;
   logic [WIDTH-1:0]  divisor_reg;
   logic              sign_q_reg;
   logic              sign_r_reg;
   logic              exc_reg;

   logic [WIDTH-1:0]  result_reg;
   logic [WIDTH-1:0]  remainder_reg;
   logic              exception_reg;
   logic              rdy_reg;

   // Control decodes from the output process of the FSM
   logic              load_op;
   logic              iterate;
   logic              finish;
   logic              last_iter;

   // Step datapath
   logic [WIDTH:0]    rem_step;
   logic [WIDTH-1:0]  q_step;

   // Operand decode at start
   logic [WIDTH-1:0]  mag_a;
   logic [WIDTH-1:0]  mag_b;
   logic              exc_start;

   // Sign-corrected final values
   logic [WIDTH-1:0]  q_final;
   logic [WIDTH-1:0]  r_final;

   assign last_iter = (cnt_reg == CNT_W'(ITER - 1));

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic. A start strobe wins from every state, so an
   // operation in BUSY or DONE is abandoned and restarted.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (ctrl_DIV) begin
         state_next = BUSY;
      end else begin
         case (state_reg)
            IDLE:    state_next = IDLE;
            BUSY:    state_next = last_iter ? DONE : BUSY;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------------
   always_comb begin
      load_op = ctrl_DIV;
      iterate = 1'b0;
      finish  = 1'b0;
      if (!ctrl_DIV) begin
         case (state_reg)
            BUSY:    iterate = 1'b1;
            DONE:    finish  = 1'b1;
            default: begin
               iterate = 1'b0;
               finish  = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Operand decode and iteration step
   // ------------------------------------------------------------------------
   always_comb begin
      mag_a     = magnitude(data_operandA);
      mag_b     = magnitude(data_operandB);
      exc_start = (data_operandB == '0) |
                  ((data_operandA == INT_MIN) & (data_operandB == NEG_ONE));
   end

   div_step u_step (
      .rem_in  (rem_reg),
      .q_in    (q_reg),
      .divisor (divisor_reg),
      .rem_out (rem_step),
      .q_out   (q_step)
   );

   // After 32 steps the remainder magnitude is below the divisor (<= 2^31),
   // so the low 32 bits carry it in full for every non-exception case.
   always_comb begin
      q_final = negate_if(sign_q_reg, q_reg);
      r_final = negate_if(sign_r_reg, rem_reg[WIDTH-1:0]);
   end

   // ------------------------------------------------------------------------
   // Operand, iteration and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg     <= '0;
         rem_reg     <= '0;
         q_reg       <= '0;
         divisor_reg <= '0;
         sign_q_reg  <= 1'b0;
         sign_r_reg  <= 1'b0;
         exc_reg     <= 1'b0;
      end else if (load_op) begin
         cnt_reg     <= '0;
         rem_reg     <= '0;
         q_reg       <= mag_a;
         divisor_reg <= mag_b;
         sign_q_reg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         sign_r_reg  <= data_operandA[WIDTH-1];
         exc_reg     <= exc_start;
      end else if (iterate) begin
         cnt_reg     <= cnt_reg + CNT_W'(1);
         rem_reg     <= rem_step;
         q_reg       <= q_step;
      end
   end

   // ------------------------------------------------------------------------
   // Output registers: loaded only when an operation completes, held
   // otherwise (including through the BUSY phase of the next operation).
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result_reg    <= '0;
         remainder_reg <= '0;
         exception_reg <= 1'b0;
         rdy_reg       <= 1'b0;
      end else begin
         rdy_reg <= finish;
         if (finish) begin
            result_reg    <= exc_reg ? '0 : q_final;
            remainder_reg <= exc_reg ? '0 : r_final;
            exception_reg <= exc_reg;
         end
      end
   end

   assign data_result    = result_reg;
   assign data_remainder = remainder_reg;
   assign data_exception = exception_reg;
   assign data_resultRDY = rdy_reg;

endmodule
